// File: rtl/i281_loader_pkg.sv
// Shared definitions for the i281 program loader: FSM states and the
// largest program (in words) a single load may carry.
package i281_loader_pkg;

  localparam int unsigned MAX_WORDS = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_HI,
    S_LO,
    S_WR,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/i281_prog_loader.sv
// Byte-stream program loader: takes a word count then big-endian 16-bit words,
// writes them to code memory 0..N-1 and holds the CPU stopped/reset meanwhile.
module i281_prog_loader
  import i281_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = MAX_WORDS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              run_req,
  output logic              run,
  output logic              cpu_reset,
  output logic              cmem_we,
  output logic [ADDR_W-1:0] cmem_addr,
  output logic [15:0]       cmem_wdata,
  output logic [ADDR_W:0]   load_count,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        lo_q, lo_d;
  logic              run_q, run_d;
  logic              settled_q, settled_d;
  logic              hdr_ok;

  assign hdr_ok = (byte_data != 8'd0) && (32'(byte_data) <= DEPTH);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    count_d = count_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_HDR;
      end
      S_HDR: begin
        if (byte_valid) begin
          if (hdr_ok) begin
            n_d     = (ADDR_W+1)'(byte_data);
            addr_d  = '0;
            count_d = '0;
            state_d = S_HI;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_HI: begin
        if (byte_valid) begin
          hi_d    = byte_data;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (byte_valid) begin
          lo_d    = byte_data;
          state_d = S_WR;
        end
      end
      S_WR: begin
        count_d = count_q + 1'b1;
        // Address stops at N-1 so a full-depth load never wraps to 0.
        if (count_d == n_q) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_HI;
        end
      end
      default: state_d = S_IDLE;
    endcase
    run_d     = run_req & ((state_d == S_IDLE) | (state_d == S_DONE));
    settled_d = (state_q == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      run_q     <= 1'b0;
      settled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      run_q     <= run_d;
      settled_q <= settled_d;
    end
  end

  assign byte_ready = (state_q == S_HDR) | (state_q == S_HI) | (state_q == S_LO);
  assign busy       = byte_ready | (state_q == S_WR);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  // Gated by reset so a write pending in the reset cycle never reaches memory.
  assign cmem_we    = (state_q == S_WR) & reset;
  assign cmem_addr  = addr_q;
  assign cmem_wdata = {hi_q, lo_q};
  assign load_count = count_q;
  assign run        = run_q;
  assign cpu_reset  = (state_q == S_IDLE) | ((state_q == S_DONE) & settled_q);

endmodule

// File: doc/i281_prog_loader.md
# i281_prog_loader

Byte-stream program loader for the i281 multicycle CPU. It sits directly upstream of the code memory write port and of the CPU `run` input. It accepts a word count followed by big-endian 16-bit instructions over a valid/ready byte interface, writes them to code memory addresses 0..N-1, and holds the CPU stopped and in reset until loading completes.

## Interface
- `ADDR_W`, 6: code memory address width.
- `DEPTH`, 64: code memory depth in words. Maximum N.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a load. Honoured in IDLE, DONE and ERR; ignored otherwise.
- `byte_valid` in 1: source has a byte.
- `byte_data` in 8: stream byte.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `run_req` in 1: user run switch.
- `run` out 1: gated run to the CPU.
- `cpu_reset` out 1: active-low CPU reset.
- `cmem_we` out 1: code memory write strobe.
- `cmem_addr` out ADDR_W: write address.
- `cmem_wdata` out 16: instruction word.
- `load_count` out ADDR_W+1: number of words written so far.
- `busy` out 1: a load is in progress.
- `done` out 1: the last load completed.
- `error` out 1: the last header was illegal.

## Operation
- States:
  - IDLE → HDR on `start`.
  - HDR: accept byte N.
    - N==0 or N>DEPTH → ERR.
    - Otherwise store N, clear address and count, → HI.
  - HI: accept byte into `wdata[15:8]` → LO.
  - LO: accept byte into `wdata[7:0]` → WR.
  - WR: `cmem_we`=1 for exactly one cycle, with `cmem_addr`=address and `cmem_wdata`=assembled word.
    - Count increments.
    - If count+1==N → DONE; else address increments and → HI.
  - DONE and ERR: hold until `start` → HDR.
- `byte_ready` = 1 only in HDR, HI and LO. A byte transfers only when `byte_valid` & `byte_ready`; the state is held otherwise with no timeout.
- `busy` = 1 in HDR, HI, LO and WR. `done` = 1 in DONE. `error` = 1 in ERR.
- `run` = `run_req` only in IDLE or DONE; otherwise 0.
- `cpu_reset` = 0 in HDR, HI, LO, WR and ERR, and for the first cycle of DONE. It is 1 in IDLE and thereafter in DONE. The CPU therefore restarts from PC 0 after every load.
- Address arithmetic:
  - The address is ADDR_W bits and never wraps: the largest N (= DEPTH) ends at address DEPTH-1 and goes to DONE.
  - `load_count` is ADDR_W+1 bits so that it can hold DEPTH.
- `start` while busy is ignored; the load continues unchanged.
- Code memory is not cleared. Words at addresses ≥ N keep their old contents.

## Timing
- All outputs are registered or decoded from the registered state. No combinational path from `byte_valid`/`byte_data` to any output.
- Reset values: state IDLE, `byte_ready`=0, `run`=0 (until `run_req` is sampled in IDLE), `cpu_reset`=1, `cmem_we`=0, `cmem_addr`=0, `cmem_wdata`=0, `load_count`=0, `busy`=0, `done`=0, `error`=0.
- Reset asserted mid-load returns to IDLE on the next edge. Any `cmem_we` in that cycle is suppressed.
- Latency:
  - `start` → `byte_ready` is 1 cycle.
  - Minimum 3 cycles per word (HI, LO, WR) with back-to-back valid bytes.
  - Total minimum for N words is 1 + 3N cycles after HDR is entered.
- `cmem_we` asserts in the cycle after the low byte is accepted. Code memory samples on that edge.
- `run` is forced low in the cycle after `start` is accepted.

## Structure
- Package `i281_loader_pkg`: state enum (IDLE, HDR, HI, LO, WR, DONE, ERR) and the `MAX_WORDS` constant (=DEPTH).
- Single module with no sub-modules; the byte assembly is just two 8-bit registers.
- At top level:
  - `cmem_we`, `cmem_addr` and `cmem_wdata` feed the code memory write port, muxed against the PC read address while `busy`.
  - `run` and `cpu_reset` drive the CPU's `run` and `reset`.

## Test plan
- `start`, then stream 02, 12 34, AB CD with continuous valid → writes 0x1234@0 and 0xABCD@1; `done`=1 after 7 cycles from HDR; `load_count`=2.
- Header 00, and separately header 65 (0x41) → ERR; `error`=1; no `cmem_we`; `run`=0 even with `run_req`=1.
- Header 0x40 followed by 64 words → last write at address 63, DONE, `load_count`=64, address does not wrap.
- `run_req`=1 throughout a load → `run`=0 while busy; `cpu_reset` low through the first DONE cycle; `run`=1 afterwards.
- Gappy source (`byte_valid` toggling) plus `start` pulsed mid-load → same memory contents as a gap-free load; the extra `start` is ignored.
- Reset asserted during LO of word 3 → next cycle IDLE with all outputs at reset values; the pending word is never written.
